// File: rtl/mem_port_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_4
// Brief    : Four-way round-robin arbiter for one shared memory/bus port, with
//            one-hot grant, mux select, ack routing and a hung-slave timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_4 #(
    parameter int TIMEOUT   = 15,
    parameter int TIMEOUT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mem_ack,
    output logic [3:0] grant,
    output logic [1:0] select,
    output logic       mem_valid,
    output logic [3:0] ack,
    output logic       timeout_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TIMEOUT_W-1:0] C_TIMEOUT = TIMEOUT_W'(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] C_CNT_MAX = {TIMEOUT_W{1'b1}};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TIMEOUT_W-1:0]   r_count;
    logic [TIMEOUT_W-1:0]   w_count_nxt;
    logic [1:0]             r_last;
    logic [1:0]             w_last_nxt;
    logic [3:0]             w_grant_nxt;
    logic [1:0]             w_select_nxt;
    logic                   w_valid_nxt;
    logic [3:0]             w_cand;
    logic [1:0]             w_cand_base;
    logic [2:0]             w_pick;
    logic                   w_at_limit;
    logic                   w_release;

    // Returns {found, index}: first asserted request scanning last+1 .. last+4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (r[idx] && !res[2]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_at_limit = (r_count == C_TIMEOUT);
    assign w_release  = (r_state == BUSY) && (mem_ack || w_at_limit);

    // In BUSY the candidate set excludes the current owner, so a requester that
    // still holds req in its own ack cycle cannot immediately win again.
    always_comb begin
        w_cand      = req;
        w_cand_base = r_last;
        if (r_state == BUSY) begin
            w_cand      = req & ~grant;
            w_cand_base = select;
        end
        w_pick = rr_pick(w_cand, w_cand_base);
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = grant;
        w_select_nxt = select;
        w_valid_nxt  = mem_valid;
        w_count_nxt  = r_count;
        w_last_nxt   = r_last;

        case (r_state)
            IDLE: begin
                if (w_pick[2]) begin
                    w_grant_nxt  = 4'b0001 << w_pick[1:0];
                    w_select_nxt = w_pick[1:0];
                    w_valid_nxt  = 1'b1;
                    w_count_nxt  = '0;
                    w_state_nxt  = BUSY;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_last_nxt = select;
                    if (w_pick[2]) begin
                        w_grant_nxt  = 4'b0001 << w_pick[1:0];
                        w_select_nxt = w_pick[1:0];
                        w_valid_nxt  = 1'b1;
                        w_count_nxt  = '0;
                        w_state_nxt  = BUSY;
                    end else begin
                        w_grant_nxt  = 4'b0000;
                        w_select_nxt = 2'b00;
                        w_valid_nxt  = 1'b0;
                        w_count_nxt  = '0;
                        w_state_nxt  = IDLE;
                    end
                end else if (r_count != C_CNT_MAX) begin
                    w_count_nxt = r_count + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            grant     <= 4'b0000;
            select    <= 2'b00;
            mem_valid <= 1'b0;
            r_count   <= '0;
            r_last    <= 2'd3;
        end else begin
            r_state   <= w_state_nxt;
            grant     <= w_grant_nxt;
            select    <= w_select_nxt;
            mem_valid <= w_valid_nxt;
            r_count   <= w_count_nxt;
            r_last    <= w_last_nxt;
        end
    end

    // Completion wins over a simultaneous timeout; acks outside BUSY are dropped.
    always_comb begin
        ack         = 4'b0000;
        timeout_err = 1'b0;
        if (r_state == BUSY) begin
            if (mem_ack) begin
                ack = grant;
            end else if (w_at_limit) begin
                timeout_err = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter_4
// Brief    : Scoreboard bench for mem_port_arbiter_4 with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter_4;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       mem_ack;
    logic [3:0] grant;
    logic [1:0] select;
    logic       mem_valid;
    logic [3:0] ack;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        int         cyc;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
    } gexp_t;

    typedef struct packed {
        int         cyc;
        logic [3:0] a;
        logic       t;
    } eexp_t;

    gexp_t gq[$];
    eexp_t eq[$];
    logic [3:0] prev_grant = 4'b0000;

    mem_port_arbiter_4 #(.TIMEOUT(15), .TIMEOUT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .select      (select),
        .mem_valid   (mem_valid),
        .ack         (ack),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Grant change expected to become visible after the next edge.
    task automatic exp_g(input logic [3:0] g, input logic [1:0] s, input logic v);
        gq.push_back('{cyc: cyc + 1, g: g, s: s, v: v});
    endtask

    // Ack / timeout event expected in the current cycle.
    task automatic exp_e(input logic [3:0] a, input logic t);
        eq.push_back('{cyc: cyc, a: a, t: t});
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req_v, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT shows a grant change or an event.
    always @(negedge clk) begin
        gexp_t ge;
        eexp_t ee;
        if (grant !== prev_grant) begin
            checks++;
            if (gq.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected: actual grant %b required no change (cycle %0d)", grant, cyc);
            end else begin
                ge = gq.pop_front();
                if (grant !== ge.g || select !== ge.s || mem_valid !== ge.v || cyc != ge.cyc) begin
                    errors++;
                    $display("FAIL grant: actual g=%b s=%0d v=%b cyc=%0d required g=%b s=%0d v=%b cyc=%0d",
                             grant, select, mem_valid, cyc, ge.g, ge.s, ge.v, ge.cyc);
                end
            end
            prev_grant = grant;
        end
        if (ack !== 4'b0000 || timeout_err !== 1'b0) begin
            checks++;
            if (eq.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: actual ack=%b terr=%b required none (cycle %0d)", ack, timeout_err, cyc);
            end else begin
                ee = eq.pop_front();
                if (ack !== ee.a || timeout_err !== ee.t || cyc != ee.cyc) begin
                    errors++;
                    $display("FAIL event: actual ack=%b terr=%b cyc=%0d required ack=%b terr=%b cyc=%0d",
                             ack, timeout_err, cyc, ee.a, ee.t, ee.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req = 4'b0000; mem_ack = 1'b0;
        step(2);
        check("reset_grant",  {4'b0, grant},  8'h00);
        check("reset_select", {6'b0, select}, 8'h00);
        check("reset_valid",  {7'b0, mem_valid}, 8'h00);
        check("reset_ack",    {4'b0, ack},    8'h00);
        check("reset_terr",   {7'b0, timeout_err}, 8'h00);
        reset = 1'b0;

        // Single transaction on requester 0
        req = 4'b0001; exp_g(4'b0001, 2'd0, 1'b1); step(1);
        step(2);
        mem_ack = 1'b1; exp_e(4'b0001, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; req = 4'b0000; step(2);

        // Full rotation with back-to-back grants from a fresh reset
        reset = 1'b1; step(1); reset = 1'b0;
        req = 4'b1111; exp_g(4'b0001, 2'd0, 1'b1); step(1);
        mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_e(4'(1 << i), 1'b0);
            exp_g(4'(1 << ((i + 1) % 4)), 2'((i + 1) % 4), 1'b1);
            step(1);
        end
        req = 4'b0000; exp_e(4'b0001, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(1);

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        check("idle_ack",  {4'b0, ack},   8'h00);
        check("idle_terr", {7'b0, timeout_err}, 8'h00);
        step(1);
        mem_ack = 1'b0;
        check("idle_grant", {4'b0, grant}, 8'h00);
        step(1);

        // Masked re-arbitration, then re-grant of the same requester
        req = 4'b0100; exp_g(4'b0100, 2'd2, 1'b1); step(1);
        mem_ack = 1'b1; exp_e(4'b0100, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; exp_g(4'b0100, 2'd2, 1'b1); step(1);
        mem_ack = 1'b1; req = 4'b0000; exp_e(4'b0100, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(1);

        // Timeout on requester 1, grant moves to requester 3
        req = 4'b0010; exp_g(4'b0010, 2'd1, 1'b1); step(1);
        req = 4'b1010; step(15);
        exp_e(4'b0000, 1'b1); exp_g(4'b1000, 2'd3, 1'b1); step(1);
        req = 4'b0000; mem_ack = 1'b1; exp_e(4'b1000, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(1);

        // Set last_grant to 0, then ack coinciding with the timeout limit
        req = 4'b0001; exp_g(4'b0001, 2'd0, 1'b1); step(1);
        mem_ack = 1'b1; req = 4'b0000; exp_e(4'b0001, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(1);
        req = 4'b0011; exp_g(4'b0010, 2'd1, 1'b1); step(1);
        step(15);
        mem_ack = 1'b1; exp_e(4'b0010, 1'b0); exp_g(4'b0001, 2'd0, 1'b1); step(1);
        req = 4'b0000; exp_e(4'b0001, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(1);

        // Reset in the middle of a transaction to requester 3
        req = 4'b1000; exp_g(4'b1000, 2'd3, 1'b1); step(1);
        step(2);
        reset = 1'b1; exp_g(4'b0000, 2'd0, 1'b0); step(1);
        reset = 1'b0; req = 4'b1001; exp_g(4'b0001, 2'd0, 1'b1); step(1);
        mem_ack = 1'b1; req = 4'b1000; exp_e(4'b0001, 1'b0); exp_g(4'b1000, 2'd3, 1'b1); step(1);
        req = 4'b0000; exp_e(4'b1000, 1'b0); exp_g(4'b0000, 2'd0, 1'b0); step(1);
        mem_ack = 1'b0; step(3);

        check("grant_queue_left", 8'(gq.size()), 8'h00);
        check("event_queue_left", 8'(eq.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
